// File: rtl/vmem_ahb_sram.sv
// AHB-Lite word-addressed SRAM slave with a two-cycle ERROR response for illegal addresses.
// Optional macro VMEM_WAIT_EN inserts WAIT_CYCLES wait states before every legal data phase.
module vmem_ahb_sram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  hsel_i,
  input  logic [1:0]            htrans_i,
  input  logic [DATA_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic [1:0]            hresp_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DATA_WIDTH-1:0] BASE_W  = DATA_WIDTH'(BASE_ADDR);
  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(DEPTH_WORDS);

`ifdef VMEM_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;
`endif

  state_e                  state_q, state_d, start_state;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   offset;
  logic                    accept;
  logic                    legal;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

`ifdef VMEM_WAIT_EN
  logic [3:0]              cnt_q, cnt_d;
`endif

  // hsize is ignored (every access is a full word) and htrans[0] only distinguishes SEQ from NONSEQ.
  logic unused_ok;
  assign unused_ok = ^{hsize_i, htrans_i[0], 4'(WAIT_CYCLES)};

  assign offset  = haddr_i - BASE_W;
  assign legal   = (haddr_i[1:0] == 2'b00) && (haddr_i >= BASE_W) && ((offset >> 2) < DEPTH_W);
  assign accept  = hready_o && hsel_i && htrans_i[1];
  assign idx_d   = accept ? IDX_W'(offset >> 2) : idx_q;
  assign write_d = accept ? hwrite_i : write_q;

`ifdef VMEM_WAIT_EN
  assign start_state = legal ? S_WAIT : S_ERR1;
`else
  assign start_state = legal ? S_DATA : S_ERR1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
`ifdef VMEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
`ifdef VMEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DATA, S_ERR2: state_d = accept ? start_state : S_IDLE;
`ifdef VMEM_WAIT_EN
      S_WAIT:                 if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = S_DATA;
`endif
      S_ERR1:                 state_d = S_ERR2;
      default:                state_d = S_IDLE;
    endcase
  end

`ifdef VMEM_WAIT_EN
  // Counter runs only while staying in WAIT, so it is zero again whenever WAIT is left.
  assign cnt_d = ((state_q == S_WAIT) && (state_d == S_WAIT)) ? cnt_q + 4'd1 : 4'd0;
`endif

  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 2'b00;
    hrdata_o = '0;
    unique case (state_q)
`ifdef VMEM_WAIT_EN
      S_WAIT: hready_o = 1'b0;
`endif
      S_DATA: if (!write_q) hrdata_o = mem_q[idx_q];
      S_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = 2'b01;
      end
      S_ERR2: hresp_o = 2'b01;
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; a reset forces IDLE, which drops any pending write.
  always_ff @(posedge clk_i) begin
    if ((state_q == S_DATA) && write_q) begin
      mem_q[idx_q] <= hwdata_i;
    end
  end

endmodule

// File: tb/tb_vmem_ahb_sram.sv
// Randomized self-checking bench for vmem_ahb_sram against an array-based memory model.
// Works for both builds; expected wait states follow VMEM_WAIT_EN.
module tb_vmem_ahb_sram;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WAITC = 2;
`ifdef VMEM_WAIT_EN
  localparam logic [7:0]  EXP_LOWS = 8'(WAITC);
`else
  localparam logic [7:0]  EXP_LOWS = 8'd0;
`endif

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        hsel_i;
  logic [1:0]  htrans_i;
  logic [31:0] haddr_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] hwdata_i;
  logic [31:0] hrdata_o;
  logic        hready_o;
  logic [1:0]  hresp_o;

  vmem_ahb_sram #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .hsel_i  (hsel_i),
    .htrans_i(htrans_i),
    .haddr_i (haddr_i),
    .hwrite_i(hwrite_i),
    .hsize_i (hsize_i),
    .hwdata_i(hwdata_i),
    .hrdata_o(hrdata_o),
    .hready_o(hready_o),
    .hresp_o (hresp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [7:0]  lows;
    logic [1:0]  stall_resp;
    logic [31:0] stall_rd;
  } obs_t;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [31:0] wd;
    bit          gap;
  } xfer_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_mem [DEPTH];

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && ((a - BASE) / 4 < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Expected observation of one transfer from the address rules and the model memory.
  function automatic obs_t model_xfer(input logic [31:0] a, input logic wr);
    obs_t e;
    bit   ok = is_legal(a);
    e.ready      = 1'b1;
    e.resp       = ok ? 2'b00 : 2'b01;
    e.lows       = ok ? EXP_LOWS : 8'd1;
    e.stall_resp = ok ? 2'b00 : 2'b01;
    e.stall_rd   = 32'h0;
    e.rdata      = (ok && !wr) ? model_mem[widx(a)] : 32'h0;
    return e;
  endfunction

  task automatic idle_bus();
    hsel_i   = 1'($urandom_range(0, 1));
    htrans_i = 2'($urandom_range(0, 1));
    haddr_i  = 32'hFFFF_FFFF;
    hwrite_i = 1'($urandom_range(0, 1));
    hsize_i  = 3'($urandom_range(0, 7));
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    hsel_i   = 1'b1;
    htrans_i = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
    haddr_i  = a;
    hwrite_i = wr;
    hsize_i  = 3'b010;
  endtask

  // Drives write data and records the data phase until hready_o rises (bounded).
  task automatic data_phase(input logic [31:0] wd, output obs_t o);
    o = '0;
    hwdata_i = wd;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk_i);
      if (hready_o === 1'b1) begin
        o.ready = 1'b1;
        o.resp  = hresp_o;
        o.rdata = hrdata_o;
        break;
      end
      o.lows       = o.lows + 8'd1;
      o.stall_resp = o.stall_resp | hresp_o;
      o.stall_rd   = o.stall_rd | hrdata_o;
      @(posedge clk_i);
      #1;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Runs a list of transfers, pipelining each address phase into the previous data phase unless gap is set.
  task automatic run_pipeline(input xfer_t q[$], input string name);
    obs_t o, e;
    @(posedge clk_i);
    #1;
    addr_phase(q[0].a, q[0].wr);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < q.size(); i++) begin
      if (i + 1 < q.size() && !q[i+1].gap) addr_phase(q[i+1].a, q[i+1].wr);
      else idle_bus();
      e = model_xfer(q[i].a, q[i].wr);
      data_phase(q[i].wd, o);
      if (q[i].wr && is_legal(q[i].a)) model_mem[widx(q[i].a)] = q[i].wd;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s[%0d] addr=%h wr=%0b: got %p required %p", name, i, q[i].a, q[i].wr, o, e);
      end
      if (i + 1 < q.size() && q[i+1].gap) begin
        addr_phase(q[i+1].a, q[i+1].wr);
        @(posedge clk_i);
        #1;
      end
    end
    idle_bus();
  endtask

  task automatic test_reset();
    resetn_i = 1'b0;
    idle_bus();
    hwdata_i = 32'h0;
    #13;
    vectors++;
    if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b resp=%b rdata=%h required 1/00/0", hready_o, hresp_o, hrdata_o);
    end
    @(negedge clk_i);
    resetn_i = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      idle_bus();
      if (i % 3 == 2) begin
        hsel_i   = 1'b0;
        htrans_i = 2'b10;
        haddr_i  = 32'h0000_0006;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      vectors++;
      if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 2'b00, 32'h0}) begin
        miscompares++;
        $display("FAIL idle[%0d]: got ready=%b resp=%b rdata=%h required 1/00/0", i, hready_o, hresp_o, hrdata_o);
      end
    end
  endtask

  task automatic test_basic();
    xfer_t q[$];
    q.push_back('{32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0});
    q.push_back('{32'h10, 1'b0, 32'h0, 1'b1});
    q.push_back('{32'h0, 1'b1, $urandom, 1'b1});
    q.push_back('{32'h0, 1'b0, 32'h0, 1'b1});
    q.push_back('{32'hFC, 1'b1, $urandom, 1'b1});
    q.push_back('{32'hFC, 1'b0, 32'h0, 1'b1});
    run_pipeline(q, "basic");
  endtask

  task automatic test_errors();
    xfer_t q[$];
    q.push_back('{32'h0, 1'b1, 32'h5A5A_0000, 1'b1});
    q.push_back('{32'h4, 1'b1, 32'hA5A5_0004, 1'b1});
    q.push_back('{32'h6, 1'b1, 32'hFFFF_FFFF, 1'b1});
    q.push_back('{BASE + 4 * DEPTH, 1'b1, 32'hFFFF_FFFF, 1'b1});
    q.push_back('{32'h6, 1'b0, 32'h0, 1'b1});
    q.push_back('{BASE + 4 * DEPTH + 4, 1'b0, 32'h0, 1'b0});
    q.push_back('{32'h4, 1'b0, 32'h0, 1'b0});
    q.push_back('{32'h0, 1'b0, 32'h0, 1'b1});
    run_pipeline(q, "errors");
  endtask

  task automatic test_back_to_back();
    xfer_t q[$];
    q.push_back('{32'h20, 1'b1, 32'h1, 1'b1});
    q.push_back('{32'h20, 1'b0, 32'h0, 1'b0});
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a = 32'h40 + 4 * 32'($urandom_range(0, 3));
      q.push_back('{a, 1'b1, $urandom, 1'b0});
      q.push_back('{a, 1'b0, 32'h0, 1'b0});
    end
    run_pipeline(q, "back_to_back");
  endtask

  task automatic test_reset_mid();
    xfer_t q[$];
    q.push_back('{32'h30, 1'b1, 32'hC0DE_0030, 1'b1});
    run_pipeline(q, "reset_prep");
    // Read in flight: outputs must clear the moment reset is asserted.
    @(posedge clk_i);
    #1;
    addr_phase(32'h30, 1'b0);
    @(posedge clk_i);
    #1;
    idle_bus();
    resetn_i = 1'b0;
    #1;
    vectors++;
    if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_read: got ready=%b resp=%b rdata=%h required 1/00/0", hready_o, hresp_o, hrdata_o);
    end
    @(negedge clk_i);
    resetn_i = 1'b1;
    // Write in flight: must be dropped.
    @(posedge clk_i);
    #1;
    addr_phase(32'h30, 1'b1);
    @(posedge clk_i);
    #1;
    idle_bus();
    hwdata_i = 32'hBAD0_BAD0;
    resetn_i = 1'b0;
    #1;
    vectors++;
    if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_write: got ready=%b resp=%b rdata=%h required 1/00/0", hready_o, hresp_o, hrdata_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    resetn_i = 1'b1;
    q.delete();
    q.push_back('{32'h30, 1'b0, 32'h0, 1'b1});
    run_pipeline(q, "reset_mid_reread");
  endtask

  task automatic test_burst();
    xfer_t q[$];
    for (int i = 0; i < 16; i++) q.push_back('{32'h80 + 32'(4 * i), 1'b1, $urandom, 1'b1});
    for (int i = 0; i < 16; i++) q.push_back('{32'h80 + 32'(4 * i), 1'b0, 32'h0, (i == 0)});
    run_pipeline(q, "burst");
  endtask

  task automatic test_random();
    xfer_t q[$];
    for (int i = 0; i < 8; i++) q.push_back('{32'(4 * i), 1'b1, $urandom, 1'b0});
    for (int i = 0; i < 60; i++) begin
      int          kind = $urandom_range(0, 9);
      logic [31:0] a;
      if (kind == 0)      a = 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
      else if (kind == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
      else                a = 32'(4 * $urandom_range(0, 7));
      q.push_back('{a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0)});
    end
    run_pipeline(q, "random");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/vmem_ahb_sram.md
VMEM_AHB_SRAM -- requirements
Module: vmem_ahb_sram

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32: data bus and word width in bits.
REQ-002 The module SHALL have parameter DEPTH_WORDS, default 1024: number of storage words.
REQ-003 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-004 The module SHALL have parameter WAIT_CYCLES, default 2, range 1..15: wait states inserted per transfer when VMEM_WAIT_EN is defined.
REQ-005 The module SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-006 The module SHALL have port resetn_i, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port hsel_i, input, 1 bit: slave select.
REQ-008 The module SHALL have port htrans_i, input, 2 bits: AHB transfer type; bit1=1 marks NONSEQ/SEQ.
REQ-009 The module SHALL have port haddr_i, input, DATA_WIDTH bits: byte address.
REQ-010 The module SHALL have port hwrite_i, input, 1 bit: 1=write, 0=read.
REQ-011 The module SHALL have port hsize_i, input, 3 bits: ignored; every access is a full word.
REQ-012 The module SHALL have port hwdata_i, input, DATA_WIDTH bits: write data, sampled in the data phase.
REQ-013 The module SHALL have port hrdata_o, output, DATA_WIDTH bits: read data.
REQ-014 The module SHALL have port hready_o, output, 1 bit: transfer-done / slave ready.
REQ-015 The module SHALL have port hresp_o, output, 2 bits: 2'b00 OKAY, 2'b01 ERROR.

Function
REQ-016 The address phase SHALL be accepted on a rising edge where hready_o=1, hsel_i=1 and htrans_i[1]=1; addr, hwrite and the range check SHALL be latched on that edge.
REQ-017 The word index SHALL be (haddr_i-BASE_ADDR)>>2, truncated to clog2(DEPTH_WORDS) bits.
REQ-018 A transfer SHALL be illegal if haddr_i[1:0]!=0, haddr_i<BASE_ADDR, or the index is >=DEPTH_WORDS.
REQ-019 The FSM SHALL have states IDLE, WAIT, DATA, ERR1 and ERR2, with these transitions:
- IDLE->WAIT for a legal transfer with VMEM_WAIT_EN defined.
- IDLE->DATA for a legal transfer without VMEM_WAIT_EN.
- IDLE->ERR1 for an illegal transfer.
REQ-020 In WAIT, hready_o SHALL be 0 and a 4-bit counter SHALL increment; the FSM SHALL move to DATA when counter==WAIT_CYCLES-1, and the counter SHALL clear on leaving WAIT.
REQ-021 In DATA, hready_o SHALL be 1 and hresp_o SHALL be 2'b00.
- Read: hrdata_o SHALL equal mem[latched index] combinationally.
- Write: hwdata_i SHALL be written to mem[latched index] at the edge ending DATA.
REQ-022 On leaving DATA, the FSM SHALL go to IDLE, or directly to WAIT/DATA/ERR1 if a new transfer is accepted in the same cycle (pipelined back-to-back transfers).
REQ-023 ERR1 SHALL drive hready_o=0 and hresp_o=2'b01, then go to ERR2; ERR2 SHALL drive hready_o=1 and hresp_o=2'b01, then go to IDLE or accept a new transfer.
REQ-024 Illegal transfers SHALL never modify memory.
REQ-025 hrdata_o SHALL be 0 in every state other than DATA-read.
REQ-026 A read in the transfer following a write to the same word SHALL return the newly written data, with no bypass stall.
REQ-027 IDLE SHALL drive hready_o=1 and hresp_o=2'b00; hsel_i=0 or htrans_i[1]=0 SHALL be ignored, and an idle haddr_i of 32'hFFFF_FFFF SHALL not cause an error.
REQ-028 Throughput SHALL be one word per WAIT_CYCLES+1 cycles with VMEM_WAIT_EN defined, and one word per cycle without it.

Reset
REQ-029 Asserting resetn_i SHALL immediately force state=IDLE, counter=0, hready_o=1, hresp_o=2'b00 and hrdata_o=0, including mid-transfer.
REQ-030 Any write in flight when resetn_i is asserted SHALL be dropped.
REQ-031 Memory contents SHALL NOT be reset and are undefined until written.

Configuration
REQ-032 The macro VMEM_WAIT_EN SHALL control wait-state insertion:
- Defined: the WAIT state and counter exist, and each legal transfer stalls WAIT_CYCLES cycles with hready_o=0.
- Undefined: the WAIT state and counter are removed, legal transfers are zero-wait, and WAIT_CYCLES is ignored.

Verification
REQ-033 Zero-wait write/read (VMEM_WAIT_EN undefined): write 32'hDEADBEEF @0x10, then read @0x10 -> hready_o stays 1 throughout and the read returns 32'hDEADBEEF the cycle after its address phase.
REQ-034 Wait states (VMEM_WAIT_EN defined, WAIT_CYCLES=2): read @0x0 -> hready_o low exactly 2 cycles, then high with the data.
REQ-035 Error responses: misaligned access @0x6, and access @BASE_ADDR+4*DEPTH_WORDS -> hready_o/hresp_o sequence 0/01 then 1/01, and memory unchanged on re-read.
REQ-036 Back-to-back pipelining: write 0x1 @0x20, then read @0x20 with no idle cycle -> the read returns 0x1.
REQ-037 Reset mid-transfer: reset asserted during WAIT of a write @0x30 -> outputs immediately hready_o=1, hresp_o=00, hrdata_o=0, and a later read @0x30 returns the prior value.
REQ-038 LSU-style burst: 16 word writes with idle haddr=0xFFFF_FFFF and htrans_i=0 between them -> no ERROR responses, and all 16 words read back correctly.
